instr_sequencer: RTL and testbench

Program sequencer that feeds the datapath control unit from a synchronous instruction ROM. It keeps a program counter and fetches each 16-bit word. It then holds `run` high while the control unit steps through its five-state sequence, and advances on `done`. It sits between the instruction memory and the control unit's `run`/`instruction`/`done` pins, and adds start/stop, single-step, halt-instruction detection and a watchdog.

---
 rtl/instr_sequencer_if.sv | 32 +++
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Signal bundle between the program sequencer, its host controls,
// the synchronous instruction ROM and the datapath control unit.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              stop;
    logic              step_mode;
    logic              step;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [15:0]       instruction;
    logic              run;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_count;
    logic              busy;
    logic              halted;
    logic              error;

    // Sequencer side
    modport master (
        input  start, stop, step_mode, step, mem_data, done,
        output mem_addr, instruction, run, pc, instr_count, busy, halted, error
    );

    // Host / ROM / control-unit side
    modport slave (
        output start, stop, step_mode, step, mem_data, done,
        input  mem_addr, instruction, run, pc, instr_count, busy, halted, error
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches 16-bit words from a synchronous ROM, holds
// run high for the control unit's five-state sequence, retires on done,
// and adds start/stop, single-step, halt-opcode detection and a watchdog.
module instr_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = (1 << ADDR_W) - 1,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    instr_sequencer_if.master  bus
);
    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(LAST_ADDR);
    localparam logic [WD_W-1:0]   LP_WD_LIM = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_MEM, S_ARM, S_RUN, S_DRAIN, S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_instr;
    logic [15:0]       r_instr_count;
    logic [WD_W-1:0]   r_wd;
    logic              r_run;
    logic              r_busy;
    logic              r_halted;
    logic              r_error;
    logic              r_stop_pend;
    logic              r_last;
    logic              w_retire;
    logic              w_wd_expire;
    logic              w_start_ok;
    logic              w_cur_busy;

    // Next-state decode plus the one-cycle retire/expire/start strobes
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_wd_expire = 1'b0;
        w_cur_busy  = (r_state != S_IDLE) && (r_state != S_HALT);
        w_start_ok  = !w_cur_busy && bus.start;
        case (r_state)
            S_IDLE, S_HALT: if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH:        w_state_nxt = S_WAIT_MEM;
            S_WAIT_MEM:     w_state_nxt = (bus.mem_data[1:0] == 2'b11) ? S_HALT : S_ARM;
            S_ARM:          if (!bus.step_mode || bus.step) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (r_wd == LP_WD_LIM) begin
                    w_wd_expire = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_DRAIN: begin
                if (r_last)                         w_state_nxt = S_HALT;
                else if (r_stop_pend || bus.stop)   w_state_nxt = S_IDLE;
                else                                w_state_nxt = S_FETCH;
            end
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; the ROM address is loaded on
    // entry to FETCH so the ROM data is ready during WAIT_MEM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_mem_addr    <= '0;
            r_instr       <= '0;
            r_instr_count <= '0;
            r_wd          <= '0;
            r_run         <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_error       <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_last        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_busy   <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
            r_halted <= (w_state_nxt == S_HALT);

            if (w_start_ok && (r_state == S_HALT)) r_pc <= '0;
            else if (w_retire)                     r_pc <= r_pc + 1'b1;

            if (w_state_nxt == S_FETCH)
                r_mem_addr <= (r_state == S_HALT) ? '0 : r_pc;

            if (r_state == S_WAIT_MEM) r_instr <= bus.mem_data;

            if (w_retire) begin
                r_instr_count <= r_instr_count + 16'd1;
                r_last        <= (r_pc == LP_LAST);
            end

            if (r_state == S_ARM)      r_wd <= '0;
            else if (r_state == S_RUN) r_wd <= r_wd + 1'b1;

            if (w_start_ok)       r_error <= 1'b0;
            else if (w_wd_expire) r_error <= 1'b1;

            if (w_state_nxt == S_IDLE)       r_stop_pend <= 1'b0;
            else if (w_cur_busy && bus.stop) r_stop_pend <= 1'b1;
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.instruction = r_instr;
    assign bus.run         = r_run;
    assign bus.pc          = r_pc;
    assign bus.instr_count = r_instr_count;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;
    assign bus.error       = r_error;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: ROM and control-unit models,
// randomized programs checked against an address-trace reference model.
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic hold_done;
    always #5 clk = ~clk;

    instr_sequencer_if #(.ADDR_W(8)) bus_a ();
    instr_sequencer_if #(.ADDR_W(2)) bus_b ();

    instr_sequencer #(.ADDR_W(8), .LAST_ADDR(255), .TIMEOUT(15)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    instr_sequencer #(.ADDR_W(2), .LAST_ADDR(3), .TIMEOUT(15)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    logic [15:0] rom_a [256];
    logic [15:0] rom_b [4];

    // Synchronous ROMs: data one cycle after address
    always @(posedge clk) bus_a.mem_data <= rom_a[bus_a.mem_addr];
    always @(posedge clk) bus_b.mem_data <= rom_b[bus_b.mem_addr];

    // Control-unit models: done on the 4th consecutive run cycle (STORE)
    int cu_a, cu_b;
    always @(posedge clk) begin
        if (reset || !bus_a.run || cu_a == 4) cu_a <= 0;
        else                                  cu_a <= cu_a + 1;
        if (reset || !bus_b.run || cu_b == 4) cu_b <= 0;
        else                                  cu_b <= cu_b + 1;
    end
    assign bus_a.done = bus_a.run && (cu_a == 3) && !hold_done;
    assign bus_b.done = bus_b.run && (cu_b == 3);

    int checks = 0;
    int errors = 0;
    int          burst_start [$];
    int          burst_len   [$];
    logic [15:0] burst_instr [$];
    int          exp_addr    [$];
    int          exp_pc;

    // Reference: list of addresses that retire from pc0 until a halt word
    // or the retirement of the last address
    function automatic void predict(input int pc0);
        int a;
        a = pc0;
        exp_addr.delete();
        for (int n = 0; n < 256; n++) begin
            if (rom_a[a][1:0] == 2'b11) break;
            exp_addr.push_back(a);
            a = (a + 1) % 256;
            if (exp_addr[exp_addr.size()-1] == 255) break;
        end
        exp_pc = a;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start on DUT A and record run bursts (cycle 1 = FETCH) until idle
    task automatic go(input int budget, output bit to);
        bit prev;
        int cyc;
        burst_start.delete(); burst_len.delete(); burst_instr.delete();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        prev = 1'b0; cyc = 1; to = 1'b0;
        forever begin
            if (bus_a.run && !prev) begin
                burst_start.push_back(cyc);
                burst_len.push_back(1);
                burst_instr.push_back(bus_a.instruction);
            end else if (bus_a.run) begin
                burst_len[burst_len.size()-1] = burst_len[burst_len.size()-1] + 1;
            end
            prev = bus_a.run;
            if (!bus_a.busy) break;
            if (cyc >= budget) begin to = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic load_straight();
        for (int i = 0; i < 256; i++) rom_a[i] = 16'h0000;
        rom_a[0] = 16'h1230; rom_a[1] = 16'h4561; rom_a[2] = 16'h789A; rom_a[3] = 16'h0003;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus_a.run !== 1'b0)    begin errors++; $display("FAIL reset_run: got %0b want 0", bus_a.run); end
        checks++; if (bus_a.busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0b want 0", bus_a.busy); end
        checks++; if (bus_a.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", bus_a.halted); end
        checks++; if (bus_a.error !== 1'b0)  begin errors++; $display("FAIL reset_error: got %0b want 0", bus_a.error); end
        checks++; if (bus_a.pc !== 8'd0)     begin errors++; $display("FAIL reset_pc: got %0d want 0", bus_a.pc); end
        checks++; if (bus_a.mem_addr !== 8'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", bus_a.mem_addr); end
        checks++; if (bus_a.instruction !== 16'd0) begin errors++; $display("FAIL reset_instr: got %0h want 0", bus_a.instruction); end
        checks++; if (bus_a.instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus_a.instr_count); end
    endtask

    task automatic test_straight_line();
        bit to;
        load_straight();
        do_reset();
        go(60, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL straight_timeout: got %0b want 0", to); end
        checks++; if (burst_start.size() !== 3) begin errors++; $display("FAIL straight_bursts: got %0d want 3", burst_start.size()); end
        for (int i = 0; i < burst_start.size() && i < 3; i++) begin
            checks++; if (burst_start[i] !== 4 + 8*i) begin errors++; $display("FAIL straight_start%0d: got %0d want %0d", i, burst_start[i], 4 + 8*i); end
            checks++; if (burst_len[i] !== 5) begin errors++; $display("FAIL straight_len%0d: got %0d want 5", i, burst_len[i]); end
            checks++; if (burst_instr[i] !== rom_a[i]) begin errors++; $display("FAIL straight_instr%0d: got %0h want %0h", i, burst_instr[i], rom_a[i]); end
        end
        checks++; if (bus_a.halted !== 1'b1) begin errors++; $display("FAIL straight_halted: got %0b want 1", bus_a.halted); end
        checks++; if (bus_a.pc !== 8'd3) begin errors++; $display("FAIL straight_pc: got %0d want 3", bus_a.pc); end
        checks++; if (bus_a.instr_count !== 16'd3) begin errors++; $display("FAIL straight_count: got %0d want 3", bus_a.instr_count); end
        checks++; if (bus_a.error !== 1'b0) begin errors++; $display("FAIL straight_error: got %0b want 0", bus_a.error); end
        checks++; if (bus_a.run !== 1'b0) begin errors++; $display("FAIL straight_run: got %0b want 0", bus_a.run); end
    endtask

    task automatic test_random_programs();
        bit to;
        int h;
        logic [15:0] w;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[1:0] == 2'b11) w[1:0] = 2'b01;
                rom_a[i] = w;
            end
            h = $urandom_range(7, 0);
            rom_a[h] = {14'($urandom), 2'b11};
            do_reset();
            for (int pass = 0; pass < 2; pass++) begin
                predict(0);
                go(8 * exp_addr.size() + 20, to);
                checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_%0d_timeout: got %0b want 0", t, pass, to); end
                checks++; if (burst_start.size() !== exp_addr.size()) begin errors++; $display("FAIL rand%0d_%0d_bursts: got %0d want %0d", t, pass, burst_start.size(), exp_addr.size()); end
                for (int i = 0; i < burst_start.size() && i < exp_addr.size(); i++) begin
                    checks++; if (burst_start[i] !== 4 + 8*i || burst_len[i] !== 5) begin errors++; $display("FAIL rand%0d_burst%0d: got start %0d len %0d want start %0d len 5", t, i, burst_start[i], burst_len[i], 4 + 8*i); end
                    checks++; if (burst_instr[i] !== rom_a[exp_addr[i]]) begin errors++; $display("FAIL rand%0d_instr%0d: got %0h want %0h", t, i, burst_instr[i], rom_a[exp_addr[i]]); end
                end
                checks++; if (bus_a.pc !== 8'(exp_pc)) begin errors++; $display("FAIL rand%0d_%0d_pc: got %0d want %0d", t, pass, bus_a.pc, exp_pc); end
                checks++; if (bus_a.instr_count !== 16'((pass + 1) * exp_addr.size())) begin errors++; $display("FAIL rand%0d_%0d_count: got %0d want %0d", t, pass, bus_a.instr_count, (pass + 1) * exp_addr.size()); end
                checks++; if (bus_a.halted !== 1'b1) begin errors++; $display("FAIL rand%0d_%0d_halted: got %0b want 1", t, pass, bus_a.halted); end
            end
        end
    endtask

    task automatic test_single_step();
        bit saw_run;
        load_straight();
        do_reset();
        bus_a.step_mode = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            saw_run = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (bus_a.run) saw_run = 1'b1;
            end
            checks++; if (saw_run !== 1'b0) begin errors++; $display("FAIL step%0d_wait_run: got %0b want 0", i, saw_run); end
            checks++; if (bus_a.instr_count !== 16'(i)) begin errors++; $display("FAIL step%0d_count_before: got %0d want %0d", i, bus_a.instr_count, i); end
            bus_a.step = 1'b1;
            @(negedge clk);
            bus_a.step = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!bus_a.run) break;
            end
            checks++; if (bus_a.pc !== 8'(i + 1)) begin errors++; $display("FAIL step%0d_pc: got %0d want %0d", i, bus_a.pc, i + 1); end
            checks++; if (bus_a.instr_count !== 16'(i + 1)) begin errors++; $display("FAIL step%0d_count: got %0d want %0d", i, bus_a.instr_count, i + 1); end
        end
        repeat (3) @(negedge clk);
        checks++; if (bus_a.halted !== 1'b1) begin errors++; $display("FAIL step_halted: got %0b want 1", bus_a.halted); end
        checks++; if (bus_a.pc !== 8'd3) begin errors++; $display("FAIL step_pc_end: got %0d want 3", bus_a.pc); end
        bus_a.step_mode = 1'b0;
    endtask

    task automatic test_stop_resume();
        bit to;
        load_straight();
        do_reset();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (bus_a.run !== 1'b1) begin errors++; $display("FAIL stop_in_run: got %0b want 1", bus_a.run); end
        bus_a.stop = 1'b1;
        @(negedge clk);
        bus_a.stop = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (!bus_a.busy) break;
            @(negedge clk);
        end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b want 0", bus_a.busy); end
        checks++; if (bus_a.halted !== 1'b0) begin errors++; $display("FAIL stop_halted: got %0b want 0", bus_a.halted); end
        checks++; if (bus_a.pc !== 8'd2) begin errors++; $display("FAIL stop_pc: got %0d want 2", bus_a.pc); end
        checks++; if (bus_a.instr_count !== 16'd2) begin errors++; $display("FAIL stop_count: got %0d want 2", bus_a.instr_count); end
        go(40, to);
        checks++; if (burst_start.size() !== 1) begin errors++; $display("FAIL resume_bursts: got %0d want 1", burst_start.size()); end
        if (burst_instr.size() > 0) begin
            checks++; if (burst_instr[0] !== rom_a[2]) begin errors++; $display("FAIL resume_instr: got %0h want %0h", burst_instr[0], rom_a[2]); end
        end
        checks++; if (bus_a.halted !== 1'b1 || bus_a.pc !== 8'd3 || bus_a.instr_count !== 16'd3) begin errors++; $display("FAIL resume_end: got halted %0b pc %0d count %0d want 1 3 3", bus_a.halted, bus_a.pc, bus_a.instr_count); end
    endtask

    task automatic test_watchdog();
        bit to;
        int runs;
        load_straight();
        do_reset();
        hold_done = 1'b0;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus_a.instr_count == 16'd1) break;
            @(negedge clk);
        end
        hold_done = 1'b1;
        runs = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_a.run) runs++;
            if (bus_a.halted) break;
        end
        checks++; if (runs !== 15) begin errors++; $display("FAIL wd_run_cycles: got %0d want 15", runs); end
        checks++; if (bus_a.halted !== 1'b1) begin errors++; $display("FAIL wd_halted: got %0b want 1", bus_a.halted); end
        checks++; if (bus_a.error !== 1'b1) begin errors++; $display("FAIL wd_error: got %0b want 1", bus_a.error); end
        checks++; if (bus_a.run !== 1'b0) begin errors++; $display("FAIL wd_run: got %0b want 0", bus_a.run); end
        checks++; if (bus_a.pc !== 8'd1 || bus_a.instr_count !== 16'd1) begin errors++; $display("FAIL wd_pc_count: got pc %0d count %0d want 1 1", bus_a.pc, bus_a.instr_count); end
        hold_done = 1'b0;
        go(60, to);
        checks++; if (burst_start.size() !== 3) begin errors++; $display("FAIL wd_restart_bursts: got %0d want 3", burst_start.size()); end
        if (burst_instr.size() > 0) begin
            checks++; if (burst_instr[0] !== rom_a[0]) begin errors++; $display("FAIL wd_restart_instr: got %0h want %0h", burst_instr[0], rom_a[0]); end
        end
        checks++; if (bus_a.error !== 1'b0) begin errors++; $display("FAIL wd_restart_error: got %0b want 0", bus_a.error); end
        checks++; if (bus_a.pc !== 8'd3 || bus_a.instr_count !== 16'd4) begin errors++; $display("FAIL wd_restart_end: got pc %0d count %0d want 3 4", bus_a.pc, bus_a.instr_count); end
    endtask

    task automatic test_wrap();
        int bursts;
        bit prev;
        rom_b[0] = 16'h0010; rom_b[1] = 16'h0021; rom_b[2] = 16'h0032; rom_b[3] = 16'h0040;
        do_reset();
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        bursts = 0; prev = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (bus_b.run && !prev) bursts++;
            prev = bus_b.run;
            if (bus_b.halted) break;
            @(negedge clk);
        end
        checks++; if (bus_b.halted !== 1'b1) begin errors++; $display("FAIL wrap_halted: got %0b want 1", bus_b.halted); end
        checks++; if (bus_b.pc !== 2'd0) begin errors++; $display("FAIL wrap_pc: got %0d want 0", bus_b.pc); end
        checks++; if (bus_b.instr_count !== 16'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", bus_b.instr_count); end
        checks++; if (bursts !== 4) begin errors++; $display("FAIL wrap_bursts: got %0d want 4", bursts); end
        checks++; if (bus_b.error !== 1'b0) begin errors++; $display("FAIL wrap_error: got %0b want 0", bus_b.error); end
    endtask

    task automatic test_reset_mid_run();
        load_straight();
        do_reset();
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (13) @(negedge clk);
        checks++; if (bus_a.run !== 1'b1 || bus_a.pc !== 8'd1) begin errors++; $display("FAIL rstmid_pre: got run %0b pc %0d want 1 1", bus_a.run, bus_a.pc); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.run !== 1'b0) begin errors++; $display("FAIL rstmid_run: got %0b want 0", bus_a.run); end
        checks++; if (bus_a.busy !== 1'b0 || bus_a.halted !== 1'b0 || bus_a.error !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy %0b halted %0b error %0b want 0 0 0", bus_a.busy, bus_a.halted, bus_a.error); end
        checks++; if (bus_a.pc !== 8'd0 || bus_a.instr_count !== 16'd0) begin errors++; $display("FAIL rstmid_pc_count: got pc %0d count %0d want 0 0", bus_a.pc, bus_a.instr_count); end
        checks++; if (bus_a.mem_addr !== 8'd0 || bus_a.instruction !== 16'd0) begin errors++; $display("FAIL rstmid_mem: got addr %0d instr %0h want 0 0", bus_a.mem_addr, bus_a.instruction); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus_a.busy !== 1'b0 || bus_a.run !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got busy %0b run %0b want 0 0", bus_a.busy, bus_a.run); end
    endtask

    initial begin
        reset = 1'b1;
        hold_done = 1'b0;
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.step_mode = 1'b0; bus_a.step = 1'b0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.step_mode = 1'b0; bus_b.step = 1'b0;
        for (int i = 0; i < 256; i++) rom_a[i] = 16'h0000;
        for (int i = 0; i < 4; i++) rom_b[i] = 16'h0000;
        @(negedge clk);
        test_reset();
        test_straight_line();
        test_random_programs();
        test_single_step();
        test_stop_resume();
        test_watchdog();
        test_wrap();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
